// File: rtl/cdb_writeback_scheduler.sv
// Round-robin writeback scheduler for the common data bus.
// Three per-unit result FIFOs (ALU=0, branch=1, mem=2) compete for a single
// registered CDB broadcast slot; one entry is granted per cycle.
module cdb_writeback_scheduler #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned ROB   = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           flush,
    input  logic           aluRequest,
    input  logic [ROB:0]   aluRob,
    input  logic [WIDTH:0] aluResult,
    input  logic           branchRequest,
    input  logic [ROB:0]   branchRob,
    input  logic [WIDTH:0] branchResult,
    input  logic           memRequest,
    input  logic [ROB:0]   memRob,
    input  logic [WIDTH:0] memResult,
    output logic           aluAvailable,
    output logic           branchAvailable,
    output logic           memAvailable,
    output logic           cdbValid,
    output logic [ROB:0]   cdbRob,
    output logic [WIDTH:0] cdbResult,
    output logic [1:0]     cdbSource
);

    localparam int          NumUnits  = 3;
    localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW      = PtrW + 1;
    localparam int unsigned EntryW    = ROB + WIDTH + 2;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    // Reduce a value in 0..5 modulo 3; keeps the priority pointer in 0..2.
    function automatic logic [1:0] mod3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? v - 3'd3 : v;
        return r[1:0];
    endfunction

    logic [NumUnits-1:0] req;
    logic [ROB:0]        in_rob    [NumUnits];
    logic [WIDTH:0]      in_result [NumUnits];

    logic [EntryW-1:0]   fifo_q  [NumUnits][DEPTH];
    logic [PtrW-1:0]     head_q  [NumUnits];
    logic [PtrW-1:0]     tail_q  [NumUnits];
    logic [CntW-1:0]     count_q [NumUnits];

    logic [NumUnits-1:0] avail;
    logic [NumUnits-1:0] push;
    logic [NumUnits-1:0] pop;

    logic [1:0]          prio_q;
    logic                grant_valid;
    logic [1:0]          grant_idx;
    logic [1:0]          cand;
    logic [EntryW-1:0]   grant_entry;

    assign req          = {memRequest, branchRequest, aluRequest};
    assign in_rob[0]    = aluRob;
    assign in_rob[1]    = branchRob;
    assign in_rob[2]    = memRob;
    assign in_result[0] = aluResult;
    assign in_result[1] = branchResult;
    assign in_result[2] = memResult;

    assign aluAvailable    = avail[0];
    assign branchAvailable = avail[1];
    assign memAvailable    = avail[2];

    // Round-robin pick of the first non-empty FIFO starting at the priority pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 0; k < NumUnits; k++) begin
            cand = mod3({1'b0, prio_q} + 3'(k));
            if (!grant_valid && count_q[cand] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_entry = fifo_q[grant_idx][head_q[grant_idx]];
    end

    // Availability from registered count only; flush suppresses both push and pop.
    always_comb begin
        avail = '0;
        push  = '0;
        pop   = '0;
        for (int i = 0; i < NumUnits; i++) begin
            avail[i] = count_q[i] < FullCount;
            push[i]  = req[i] && avail[i] && !flush;
            pop[i]   = grant_valid && (grant_idx == 2'(i)) && !flush;
        end
    end

    // FIFO pointers and occupancy; flush empties every queue.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NumUnits; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NumUnits; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumUnits; i++) begin
                if (push[i]) tail_q[i] <= tail_q[i] + PtrW'(1);
                if (pop[i])  head_q[i] <= head_q[i] + PtrW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CntW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CntW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumUnits; i++) begin
            if (push[i]) fifo_q[i][tail_q[i]] <= {in_rob[i], in_result[i]};
        end
    end

    // Registered CDB broadcast and priority pointer; data fields hold when idle.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cdbValid  <= 1'b0;
            cdbRob    <= '0;
            cdbResult <= '0;
            cdbSource <= 2'd0;
            prio_q    <= 2'd0;
        end else if (flush) begin
            cdbValid <= 1'b0;
        end else if (grant_valid) begin
            cdbValid              <= 1'b1;
            {cdbRob, cdbResult}   <= grant_entry;
            cdbSource             <= grant_idx;
            prio_q                <= mod3({1'b0, grant_idx} + 3'd1);
        end else begin
            cdbValid <= 1'b0;
        end
    end

endmodule
